// File: rtl/pattern_tx_if.sv
// Handshake and serial-output bundle for pattern_tx.
// The master modport drives requests and observes the stream; the slave modport is the transmitter side.
interface pattern_tx_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LENW  = 5
);
  logic             start_i;
  logic [WIDTH-1:0] pattern_i;
  logic [LENW-1:0]  length_i;
  logic             repeat_i;
  logic             abort_i;
  logic             w_o;
  logic             w_valid_o;
  logic             busy_o;
  logic             done_o;
  logic [LENW-1:0]  bit_cnt_o;

  modport master (
    output start_i, pattern_i, length_i, repeat_i, abort_i,
    input  w_o, w_valid_o, busy_o, done_o, bit_cnt_o
  );

  modport slave (
    input  start_i, pattern_i, length_i, repeat_i, abort_i,
    output w_o, w_valid_o, busy_o, done_o, bit_cnt_o
  );
endinterface

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out LSB first on w,
// optionally looping, with a one-cycle DONE marker after a non-repeating pass.
module pattern_tx #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LENW  = 5
) (
  input  logic         clk,
  input  logic         resetn,
  pattern_tx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LENW-1:0]  len_q, len_d;
  logic [LENW-1:0]  cnt_q, cnt_d;
  logic             w_q, w_d;
  logic             w_valid_q, w_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             last;
  logic             accept;
  logic [LENW-1:0]  len_eff;
  logic [WIDTH-1:0] pat_sh;

  assign last    = (cnt_q == len_q - LENW'(1));
  // A start seen during DONE is taken so back-to-back passes leave a single bubble.
  assign accept  = (state_q != SHIFT) && bus.start_i && !bus.abort_i;
  assign len_eff = ((bus.length_i == '0) || (bus.length_i > LENW'(WIDTH)))
                   ? LENW'(WIDTH) : bus.length_i;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = SHIFT;
      SHIFT:   if (last && !bus.repeat_i) state_d = DONE;
      DONE:    state_d = bus.start_i ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort_i) state_d = IDLE;
  end

  // Capture, bit counter and next output values, aligned with state_d.
  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    cnt_d = '0;
    if (accept) begin
      pat_d = bus.pattern_i;
      len_d = len_eff;
    end else if (state_d == SHIFT) begin
      cnt_d = last ? '0 : cnt_q + LENW'(1);
    end
    pat_sh    = pat_d >> cnt_d;
    w_d       = (state_d == SHIFT) && pat_sh[0];
    w_valid_d = (state_d == SHIFT);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  assign bus.w_o       = w_q;
  assign bus.w_valid_o = w_valid_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.bit_cnt_o = cnt_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Directed self-checking bench for pattern_tx; each check compares the packed
// output tuple {w, w_valid, busy, done, bit_cnt} against a hand-derived value.
module tb_pattern_tx;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned LENW  = 5;

  logic clk;
  logic resetn;
  int   compared;
  int   mismatched;

  pattern_tx_if #(.WIDTH(WIDTH), .LENW(LENW)) bus ();

  pattern_tx #(.WIDTH(WIDTH), .LENW(LENW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] vec(input logic w, input logic wv, input logic b,
                                     input logic d, input int cnt);
    return {w, wv, b, d, 5'(cnt)};
  endfunction

  function automatic logic [8:0] sh(input logic w, input int cnt);
    return vec(w, 1'b1, 1'b1, 1'b0, cnt);
  endfunction

  localparam logic [8:0] DN = 9'b0_0_1_1_00000;
  localparam logic [8:0] ID = 9'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {bus.w_o, bus.w_valid_o, bus.busy_o, bus.done_o, bus.bit_cnt_o};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed w/v/busy/done/cnt=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] pref;
    logic [4:0]  lens [2];
    logic [2:0]  p5;
    compared   = 0;
    mismatched = 0;
    resetn        = 1'b0;
    bus.start_i   = 1'b0;
    bus.pattern_i = '0;
    bus.length_i  = '0;
    bus.repeat_i  = 1'b0;
    bus.abort_i   = 1'b0;

    // Reset, with start/abort/repeat high to confirm reset wins.
    step();
    bus.start_i = 1'b1; bus.repeat_i = 1'b1; bus.abort_i = 1'b1;
    step();
    chk("reset", ID);
    bus.start_i = 1'b0; bus.repeat_i = 1'b0; bus.abort_i = 1'b0;
    resetn = 1'b1;
    step();
    chk("idle after reset", ID);

    // Single 4-bit pass; inputs changed after capture must not matter.
    bus.pattern_i = 16'h000F; bus.length_i = 5'd4; bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0; bus.pattern_i = 16'h0000; bus.length_i = 5'd1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1 bit %0d", i), sh(1'b1, i));
      if (i < 3) step();
    end
    step(); chk("t1 done", DN);
    step(); chk("t1 idle", ID);

    // Repeat loop of 101, with a start pulse while busy that must be ignored.
    p5 = 3'b101;
    bus.pattern_i = 16'h0005; bus.length_i = 5'd3; bus.repeat_i = 1'b1; bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t2 bit %0d", i), sh(p5[i % 3], i % 3));
      if (i == 4) begin bus.start_i = 1'b1; bus.pattern_i = 16'hFFFF; bus.length_i = 5'd7; end
      if (i == 5) bus.start_i = 1'b0;
      if (i == 8) bus.repeat_i = 1'b0;
      if (i < 8) step();
    end
    step(); chk("t2 done", DN);
    step(); chk("t2 idle", ID);

    // Length 0 and length 20 both send the full 16 bits.
    pref = 16'hA5C3;
    lens[0] = 5'd0; lens[1] = 5'd20;
    for (int k = 0; k < 2; k++) begin
      bus.pattern_i = pref; bus.length_i = lens[k]; bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("t3 len%0d bit %0d", lens[k], i), sh(pref[i], i));
        if (i < 15) step();
      end
      step(); chk($sformatf("t3 len%0d done", lens[k]), DN);
      step(); chk($sformatf("t3 len%0d idle", lens[k]), ID);
    end

    // Back-to-back: start held through DONE gives a single bubble.
    bus.pattern_i = 16'h0006; bus.length_i = 5'd3; bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    chk("t4 p1 bit 0", sh(1'b0, 0));
    step(); chk("t4 p1 bit 1", sh(1'b1, 1));
    step(); chk("t4 p1 bit 2", sh(1'b1, 2));
    bus.start_i = 1'b1; bus.pattern_i = 16'h0001; bus.length_i = 5'd2;
    step(); chk("t4 bubble", DN);
    step(); chk("t4 p2 bit 0", sh(1'b1, 0));
    bus.start_i = 1'b0;
    step(); chk("t4 p2 bit 1", sh(1'b0, 1));
    step(); chk("t4 p2 done", DN);
    step(); chk("t4 p2 idle", ID);

    // Abort during bit 2 beats simultaneous start and repeat.
    bus.pattern_i = 16'h00B4; bus.length_i = 5'd8; bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    chk("t5 bit 0", sh(1'b0, 0));
    step(); chk("t5 bit 1", sh(1'b0, 1));
    step(); chk("t5 bit 2", sh(1'b1, 2));
    bus.abort_i = 1'b1; bus.start_i = 1'b1; bus.repeat_i = 1'b1;
    step(); chk("t5 aborted", ID);
    step(); chk("t5 abort holds idle", ID);
    bus.abort_i = 1'b0; bus.start_i = 1'b0; bus.repeat_i = 1'b0;
    step(); chk("t5 idle", ID);

    // Reset mid-pass at bit 5, then a start right after release.
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t6 bit %0d", i), sh(pref[0] & 1'b0 | (i == 2 || i == 4 || i == 5), i));
      if (i < 5) step();
    end
    resetn = 1'b0; bus.start_i = 1'b1;
    step(); chk("t6 reset", ID);
    resetn = 1'b1; bus.pattern_i = 16'h0003; bus.length_i = 5'd2;
    step(); chk("t6 restart bit 0", sh(1'b1, 0));
    bus.start_i = 1'b0;
    step(); chk("t6 restart bit 1", sh(1'b1, 1));
    step(); chk("t6 restart done", DN);
    step(); chk("t6 restart idle", ID);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
